startup_gen: RTL and testbench

STARTUP_GEN -- requirements
Module: startup_gen

---
 rtl/drsstc_pkg.sv | 19 +
 rtl/edge_det.sv | 31 +++
 rtl/startup_gen.sv | 167 ++++++++++++++++
 tb/tb_startup_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drsstc_pkg.sv
// Shared FSM state type and timing helpers for the DRSSTC startup/interrupter blocks.
package drsstc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Clock cycles per half period of the startup drive (expected integer, >= 2).
  function automatic int half_cycles(input int clk_mhz, input int gen_khz);
    return (clk_mhz * 1000) / (2 * gen_khz);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/edge_det.sv
// Single-bit edge detector: registered history plus combinational rise/fall/any-edge flags.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic any
);

  logic hist_d, hist_q;

  // Next history value is simply the current sample.
  always_comb begin
    hist_d = d;
  end

  // History register, cleared by reset so a level held through reset reads as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise = d & ~hist_q;
  assign fall = ~d & hist_q;
  assign any  = d ^ hist_q;

endmodule

// File: rtl/startup_gen.sv
// Startup square-wave generator for the DRSSTC feedback selector (IDLE/RUN/HOLD).
// Define STARTUP_GEN_FAIL_CNT_EN to build the saturating fail_cnt counter; otherwise fail_cnt reads 0.
module startup_gen
  import drsstc_pkg::*;
#(
  parameter int CLK_MHZ      = 100,
  parameter int GEN_FREQ_KHZ = 500,
  parameter int MAX_PERIODS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lock,
  output logic       gen,
  output logic       active,
  output logic       fail,
  output logic [7:0] fail_cnt
);

  localparam int HALF = half_cycles(CLK_MHZ, GEN_FREQ_KHZ);
  localparam int HCW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PCW  = $clog2(MAX_PERIODS + 1);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF - 1);
  localparam logic [PCW-1:0] PER_MAX   = PCW'(MAX_PERIODS);

  state_e         state_q, state_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           gen_q, gen_d;
  logic           active_q, active_d;
  logic           fail_q, fail_d;
  logic           stop_en_q, stop_en_d;
  logic           stop_lock_q, stop_lock_d;
  logic           en_rise, en_fall, en_any;
  logic           half_done;

  edge_det u_en_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (en),
    .rise (en_rise),
    .fall (en_fall),
    .any  (en_any)
  );

  assign half_done = (hcnt_q == HALF_LAST);

  // Next-state logic. RUN is entered with en high, so inside RUN and HOLD the first low sample
  // of en always shows up as an edge; stop requests latch until gen is low.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    gen_d       = gen_q;
    fail_d      = 1'b0;
    stop_en_d   = stop_en_q | en_fall;
    stop_lock_d = stop_lock_q | lock;
    case (state_q)
      ST_IDLE: begin
        gen_d       = 1'b0;
        stop_en_d   = 1'b0;
        stop_lock_d = 1'b0;
        if (en_rise) begin
          state_d = ST_RUN;
          gen_d   = 1'b1;
          hcnt_d  = '0;
          pcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!gen_q && stop_en_d) begin
          state_d = ST_IDLE;
        end else if (!gen_q && stop_lock_d) begin
          state_d = ST_HOLD;
        end else if (!half_done) begin
          hcnt_d = hcnt_q + 1'b1;
        end else if (gen_q) begin
          hcnt_d = '0;
          gen_d  = 1'b0;
          pcnt_d = pcnt_q + 1'b1;
          if (stop_en_d) begin
            state_d = ST_IDLE;
          end else if (stop_lock_d) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (pcnt_q == PER_MAX) begin
          state_d = ST_HOLD;
          fail_d  = 1'b1;
        end else begin
          hcnt_d = '0;
          gen_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        gen_d       = 1'b0;
        stop_en_d   = 1'b0;
        stop_lock_d = 1'b0;
        if (en_any) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gen_d       = 1'b0;
        stop_en_d   = 1'b0;
        stop_lock_d = 1'b0;
      end
    endcase
    active_d = (state_d == ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hcnt_q      <= '0;
      pcnt_q      <= '0;
      gen_q       <= 1'b0;
      active_q    <= 1'b0;
      fail_q      <= 1'b0;
      stop_en_q   <= 1'b0;
      stop_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      gen_q       <= gen_d;
      active_q    <= active_d;
      fail_q      <= fail_d;
      stop_en_q   <= stop_en_d;
      stop_lock_q <= stop_lock_d;
    end
  end

  assign gen    = gen_q;
  assign active = active_q;
  assign fail   = fail_q;

`ifdef STARTUP_GEN_FAIL_CNT_EN
  logic [7:0] fail_cnt_q, fail_cnt_d;

  // Saturating count of fail pulses.
  always_comb begin
    fail_cnt_d = fail_d ? sat_inc8(fail_cnt_q) : fail_cnt_q;
  end

  // Fail counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt_q <= 8'd0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign fail_cnt = fail_cnt_q;
`else
  assign fail_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_startup_gen.sv
// Bench for startup_gen: timeline table on the default build, corner sequences and a
// randomized run against a position-based model on a fast build, plus fail_cnt saturation.
module tb_startup_gen;

`ifdef STARTUP_GEN_FAIL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int FH   = 2;
  localparam int FMAX = 2;

  typedef struct {
    int lock_at;
    int drop_at;
    int rerise_at;
    int rst_at;
    int ncyc;
    int nfail;
  } scn_t;

  typedef struct {
    int scn;
    int cyc;
    bit g;
    bit a;
    bit f;
  } chk_t;

  logic       clk = 1'b0;
  logic       rst, en, lock, gen, active, fail;
  logic [7:0] fail_cnt;
  logic       f_rst, f_en, f_lock, f_gen, f_active, f_fail;
  logic [7:0] f_fail_cnt;

  int   nvec = 0;
  int   nmis = 0;
  int   nfail_s;
  logic gen_tr  [0:1800];
  logic act_tr  [0:1800];
  logic fail_tr [0:1800];
  scn_t scns [5];
  chk_t chks [$];

  int m_state, m_pos, m_cnt;
  bit m_prev, m_se, m_sl, m_gen, m_act, m_fail;

  always #5 clk = ~clk;

  startup_gen u_dut (
    .clk(clk), .rst(rst), .en(en), .lock(lock),
    .gen(gen), .active(active), .fail(fail), .fail_cnt(fail_cnt)
  );

  startup_gen #(.CLK_MHZ(4), .GEN_FREQ_KHZ(1000), .MAX_PERIODS(FMAX)) u_fast (
    .clk(clk), .rst(f_rst), .en(f_en), .lock(f_lock),
    .gen(f_gen), .active(f_active), .fail(f_fail), .fail_cnt(f_fail_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic scn_t mk_scn(int la, int da, int ra, int rr, int n, int nf);
    scn_t s;
    s.lock_at = la; s.drop_at = da; s.rerise_at = ra; s.rst_at = rr; s.ncyc = n; s.nfail = nf;
    return s;
  endfunction

  function automatic chk_t mk_chk(int s, int c, bit g, bit a, bit f);
    chk_t k;
    k.scn = s; k.cyc = c; k.g = g; k.a = a; k.f = f;
    return k;
  endfunction

  // Default-build timeline: cycle k inputs are sampled by the edge that produces cycle k+1 outputs.
  task automatic run_scn(input scn_t sc);
    rst = 1'b1; en = 1'b0; lock = 1'b0;
    tick();
    check("reset gen", gen, 0);
    check("reset active", active, 0);
    check("reset fail", fail, 0);
    check("reset fail_cnt", fail_cnt, 0);
    rst = 1'b0;
    nfail_s = 0;
    for (int k = 0; k < sc.ncyc; k++) begin
      en   = (k >= 10) && !(sc.drop_at >= 0 && k >= sc.drop_at && (sc.rerise_at < 0 || k < sc.rerise_at));
      lock = (sc.lock_at >= 0) && (k >= sc.lock_at);
      rst  = (k == sc.rst_at);
      tick();
      gen_tr[k+1]  = gen;
      act_tr[k+1]  = active;
      fail_tr[k+1] = fail;
      if (fail === 1'b1) nfail_s++;
    end
    rst = 1'b0;
  endtask

  // Reference: burst position counted from RUN entry; level and period follow by division.
  task automatic model_step(input bit r, input bit e, input bit l);
    bit rise, ph_high, last;
    if (r) begin
      m_state = 0; m_pos = 0; m_cnt = 0; m_prev = 1'b0;
      m_se = 1'b0; m_sl = 1'b0; m_fail = 1'b0;
    end else begin
      rise   = e && !m_prev;
      m_prev = e;
      m_fail = 1'b0;
      case (m_state)
        0: if (rise) begin m_state = 1; m_pos = 0; m_se = 1'b0; m_sl = 1'b0; end
        1: begin
          if (!e) m_se = 1'b1;
          if (l)  m_sl = 1'b1;
          ph_high = (m_pos % (2*FH)) < FH;
          last    = (m_pos % FH) == FH - 1;
          if (!ph_high && m_se) m_state = 0;
          else if (!ph_high && m_sl) m_state = 2;
          else if (ph_high && last && m_se) m_state = 0;
          else if (ph_high && last && m_sl) m_state = 2;
          else if (!ph_high && last && (m_pos + 1) / (2*FH) == FMAX) begin
            m_state = 2; m_fail = 1'b1;
          end else m_pos++;
        end
        default: if (!e) m_state = 0;
      endcase
      if (m_fail && CNT_EN && m_cnt < 255) m_cnt++;
    end
    m_act = (m_state == 1);
    m_gen = m_act && ((m_pos % (2*FH)) < FH);
  endtask

  task automatic fast_reset();
    f_rst = 1'b1; f_en = 1'b0; f_lock = 1'b0;
    tick();
    model_step(1'b1, 1'b0, 1'b0);
    f_rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nseen;
    bit seen;
    rst = 1'b1; en = 1'b0; lock = 1'b0;
    f_rst = 1'b1; f_en = 1'b0; f_lock = 1'b0;

    scns[0] = mk_scn(-1,  -1,  -1,  -1, 1700, 1);
    scns[1] = mk_scn(150, -1,  -1,  -1, 1100, 0);
    scns[2] = mk_scn(50,  -1,  -1,  -1,  400, 0);
    scns[3] = mk_scn(-1,  60, 300,  -1,  500, 0);
    scns[4] = mk_scn(-1,  -1,  -1, 500,  700, 0);
    chks.push_back(mk_chk(0, 10, 0, 0, 0));   chks.push_back(mk_chk(0, 11, 1, 1, 0));
    chks.push_back(mk_chk(0, 110, 1, 1, 0));  chks.push_back(mk_chk(0, 111, 0, 1, 0));
    chks.push_back(mk_chk(0, 210, 0, 1, 0));  chks.push_back(mk_chk(0, 211, 1, 1, 0));
    chks.push_back(mk_chk(0, 1510, 1, 1, 0)); chks.push_back(mk_chk(0, 1511, 0, 1, 0));
    chks.push_back(mk_chk(0, 1610, 0, 1, 0)); chks.push_back(mk_chk(0, 1611, 0, 0, 1));
    chks.push_back(mk_chk(0, 1612, 0, 0, 0)); chks.push_back(mk_chk(0, 1700, 0, 0, 0));
    chks.push_back(mk_chk(1, 150, 0, 1, 0));  chks.push_back(mk_chk(1, 151, 0, 0, 0));
    chks.push_back(mk_chk(1, 211, 0, 0, 0));  chks.push_back(mk_chk(1, 1100, 0, 0, 0));
    chks.push_back(mk_chk(2, 50, 1, 1, 0));   chks.push_back(mk_chk(2, 110, 1, 1, 0));
    chks.push_back(mk_chk(2, 111, 0, 0, 0));  chks.push_back(mk_chk(2, 211, 0, 0, 0));
    chks.push_back(mk_chk(3, 60, 1, 1, 0));   chks.push_back(mk_chk(3, 110, 1, 1, 0));
    chks.push_back(mk_chk(3, 111, 0, 0, 0));  chks.push_back(mk_chk(3, 300, 0, 0, 0));
    chks.push_back(mk_chk(3, 301, 1, 1, 0));  chks.push_back(mk_chk(3, 400, 1, 1, 0));
    chks.push_back(mk_chk(3, 401, 0, 1, 0));
    chks.push_back(mk_chk(4, 500, 1, 1, 0));  chks.push_back(mk_chk(4, 501, 0, 0, 0));
    chks.push_back(mk_chk(4, 502, 1, 1, 0));  chks.push_back(mk_chk(4, 601, 1, 1, 0));
    chks.push_back(mk_chk(4, 602, 0, 1, 0));

    for (int s = 0; s < 5; s++) begin
      run_scn(scns[s]);
      foreach (chks[i]) begin
        if (chks[i].scn == s) begin
          check($sformatf("scn%0d c%0d gen", s, chks[i].cyc), gen_tr[chks[i].cyc], chks[i].g);
          check($sformatf("scn%0d c%0d active", s, chks[i].cyc), act_tr[chks[i].cyc], chks[i].a);
          check($sformatf("scn%0d c%0d fail", s, chks[i].cyc), fail_tr[chks[i].cyc], chks[i].f);
        end
      end
      check($sformatf("scn%0d fail pulses", s), nfail_s, scns[s].nfail);
      if (s == 0) check("scn0 fail_cnt", fail_cnt, CNT_EN ? 1 : 0);
    end
    rst = 1'b1;

    // Lock arriving on the last low cycle of the final period wins over fail.
    fast_reset();
    n = 0;
    for (int k = 0; k < 12; k++) begin
      f_en = 1'b1;
      f_lock = (k == 8);
      tick();
      if (f_fail === 1'b1) n++;
      if (k + 1 == 5) check("lockfinal gen c5", f_gen, 1);
      if (k + 1 == 9) check("lockfinal active c9", f_active, 0);
    end
    check("lockfinal fail pulses", n, 0);

    // en low together with lock goes to IDLE, so an immediate re-rise restarts the burst.
    fast_reset();
    for (int k = 0; k < 7; k++) begin
      f_en = (k != 3);
      f_lock = (k == 3);
      tick();
      if (k + 1 == 4) begin
        check("enlock gen c4", f_gen, 0);
        check("enlock active c4", f_active, 0);
      end
      if (k + 1 == 5) begin
        check("enlock gen c5", f_gen, 1);
        check("enlock active c5", f_active, 1);
      end
    end

    // Randomized run against the reference model.
    fast_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) f_en = ~f_en;
      if (f_lock) begin
        if ($urandom_range(0, 3) == 0) f_lock = 1'b0;
      end else begin
        if ($urandom_range(0, 39) == 0) f_lock = 1'b1;
      end
      f_rst = ($urandom_range(0, 299) == 0);
      tick();
      model_step(f_rst, f_en, f_lock);
      check($sformatf("rnd%0d gen", k), f_gen, m_gen);
      check($sformatf("rnd%0d active", k), f_active, m_act);
      check($sformatf("rnd%0d fail", k), f_fail, m_fail);
      check($sformatf("rnd%0d fail_cnt", k), f_fail_cnt, m_cnt);
    end
    f_rst = 1'b0;

    // 300 back-to-back failed bursts: counter must saturate, never wrap.
    fast_reset();
    nseen = 0;
    for (int b = 0; b < 300; b++) begin
      seen = 1'b0;
      f_en = 1'b1;
      for (int w = 0; w < 40 && !seen; w++) begin
        tick();
        if (f_fail === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        check("sat burst timeout", 0, 1);
        break;
      end
      nseen++;
      f_en = 1'b0;
      tick();
    end
    check("sat fail pulses", nseen, 300);
    check("sat fail_cnt", f_fail_cnt, CNT_EN ? 255 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
